// File: rtl/aether_cmd_decoder.sv
`timescale 1ns/1ps
// aether_cmd_decoder
// Decodes a 24-bit command word {op, sub, arg} every cycle into soft-reset
// pulses, configuration register writes and reads, and pushes into a small
// task FIFO that feeds a downstream engine.
// Build option: define AETHER_CMD_DECODER_ERR_EN to get a sticky err_o for
// illegal commands and dropped pushes. When it is not defined, err_o is tied low.
module aether_cmd_decoder #(
  parameter int FifoDepth = 4,
  parameter int RegCount  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [23:0] cmd_i,
  output logic        task_valid_o,
  input  logic        task_ready_i,
  output logic [3:0]  task_op_o,
  output logic [15:0] task_arg_o,
  output logic [3:0]  soft_rst_o,
  output logic [15:0] data_o,
  output logic        data_valid_o,
  output logic        buffer_full_o,
  output logic        interrupt_o,
  output logic        err_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int RegAw = (RegCount > 1) ? $clog2(RegCount) : 1;
  localparam logic [CntW-1:0] DepthC    = CntW'(FifoDepth);
  localparam logic [4:0]      RegCountC = 5'(RegCount);

  localparam logic [3:0] OpReset = 4'd1;
  localparam logic [3:0] OpWrite = 4'd2;
  localparam logic [3:0] OpRead  = 4'd3;
  localparam logic [3:0] OpStart = 4'd4;

  logic [3:0]  op;
  logic [3:0]  sub;
  logic [15:0] arg;

  assign op  = cmd_i[23:20];
  assign sub = cmd_i[19:16];
  assign arg = cmd_i[15:0];

  // Task FIFO state
  logic [19:0]     fifo_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [19:0]     head;

  // Configuration registers and registered outputs
  logic [15:0] reg_q [RegCount];
  logic [15:0] rd_val;
  logic [3:0]  srst_q, srst_d;
  logic [15:0] data_q, data_d;
  logic        dv_q, full_q, irq_q;
  logic        full_d, irq_d;

  // Command decode
  logic flush, rst_cmd, reg_hit, wr_en, rd_en, push_req, push, pop;

  assign rst_cmd  = (op == OpReset) && (sub[3:2] == 2'b00);
  assign flush    = (op == OpReset) && (sub == 4'd0);
  assign reg_hit  = ({1'b0, sub} < RegCountC);
  assign wr_en    = (op == OpWrite) && reg_hit;
  assign rd_en    = (op == OpRead);
  assign push_req = (op == OpStart) && !sub[3];
  // A flush wins over a pop that would otherwise happen on the same edge.
  assign pop      = task_valid_o && task_ready_i && !flush;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && ((cnt_q != DepthC) || pop);

  assign rd_val = reg_hit ? reg_q[sub[RegAw-1:0]] : 16'h0000;
  assign head   = fifo_q[rd_ptr_q];

  // Next-state for FIFO pointers, occupancy and the pulse/data outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
    srst_d = rst_cmd ? (4'b0001 << sub[1:0]) : 4'b0000;
    data_d = rd_en ? rd_val : data_q;
    full_d = (cnt_d == DepthC);
    irq_d  = pop && !push && (cnt_q == CntW'(1));
  end

  // FIFO storage; entries are only visible through the valid-gated head
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {sub, arg};
  end

  // FIFO control and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      srst_q   <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      full_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      srst_q   <= srst_d;
      data_q   <= data_d;
      dv_q     <= rd_en;
      full_q   <= full_d;
      irq_q    <= irq_d;
    end
  end

  // Configuration register file; RESET-ALL clears it alongside the FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegCount; i++) reg_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RegCount; i++) reg_q[i] <= '0;
    end else if (wr_en) begin
      reg_q[sub[RegAw-1:0]] <= arg;
    end
  end

`ifdef AETHER_CMD_DECODER_ERR_EN
  logic err_q;
  logic illegal;

  assign illegal = (op > OpStart)
                 || ((op == OpReset) && !rst_cmd)
                 || ((op == OpStart) && sub[3])
                 || (push_req && !push);

  // Sticky error flag, cleared only by reset or RESET-ALL
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (flush)   err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign task_valid_o  = (cnt_q != '0);
  assign task_op_o     = task_valid_o ? head[19:16] : 4'h0;
  assign task_arg_o    = task_valid_o ? head[15:0]  : 16'h0000;
  assign soft_rst_o    = srst_q;
  assign data_o        = data_q;
  assign data_valid_o  = dv_q;
  assign buffer_full_o = full_q;
  assign interrupt_o   = irq_q;

endmodule

// File: tb/tb_aether_cmd_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for aether_cmd_decoder: a queue-based reference model
// predicts each post-edge output set; a monitor pops and compares them.
module tb_aether_cmd_decoder;

  localparam int DEPTH = 4;
`ifdef AETHER_CMD_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [23:0] cmd_i = '0;
  logic        task_ready_i = 1'b0;
  logic        task_valid_o;
  logic [3:0]  task_op_o;
  logic [15:0] task_arg_o;
  logic [3:0]  soft_rst_o;
  logic [15:0] data_o;
  logic        data_valid_o;
  logic        buffer_full_o;
  logic        interrupt_o;
  logic        err_o;

  aether_cmd_decoder #(.FifoDepth(DEPTH), .RegCount(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_i(cmd_i),
    .task_valid_o(task_valid_o), .task_ready_i(task_ready_i),
    .task_op_o(task_op_o), .task_arg_o(task_arg_o),
    .soft_rst_o(soft_rst_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .buffer_full_o(buffer_full_o), .interrupt_o(interrupt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  srst;
    logic        dv;
    logic        full;
    logic        irq;
    logic        err;
    logic        tv;
    logic [3:0]  top;
    logic [15:0] targ;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];

  // Reference model state
  logic [19:0] mq[$];
  logic [15:0] mregs[16];
  bit          merr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (mregs[i]) mregs[i] = '0;
    merr = 1'b0;
  endtask

  // Apply one command now and predict the outputs after the next rising edge.
  task automatic drive(input logic [23:0] c, input logic r);
    exp_t e;
    logic [3:0] op, sub;
    logic [15:0] arg;
    bit flush, pop, push_req, push, illegal;
    int n0;
    cmd_i = c;
    task_ready_i = r;
    op = c[23:20]; sub = c[19:16]; arg = c[15:0];
    n0 = mq.size();
    flush    = (op == 4'd1) && (sub == 4'd0);
    pop      = (n0 > 0) && r && !flush;
    push_req = (op == 4'd4) && (sub < 4'd8);
    push     = push_req && ((n0 < DEPTH) || pop);
    illegal  = (op >= 4'd5) || ((op == 4'd1) && (sub >= 4'd4)) ||
               ((op == 4'd4) && (sub >= 4'd8)) || (push_req && !push);
    e = '0;
    if (op == 4'd1 && sub < 4'd4) e.srst = 4'b0001 << sub[1:0];
    if (op == 4'd3) begin
      e.dv = 1'b1;
      rd_q.push_back(mregs[sub]);
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({sub, arg});
    if (op == 4'd2) mregs[sub] = arg;
    if (flush) model_reset();
    else if (ERR_EN && illegal) merr = 1'b1;
    e.irq  = pop && !push && (n0 == 1);
    e.full = (mq.size() == DEPTH);
    e.tv   = (mq.size() > 0);
    if (e.tv) begin
      e.top  = mq[0][19:16];
      e.targ = mq[0][15:0];
    end
    e.err = merr;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [23:0] c, input logic r);
    @(negedge clk_i);
    drive(c, r);
  endtask

  // Let the last driven command take its edge, then idle the inputs.
  task automatic quiesce();
    @(posedge clk_i);
    #3;
    cmd_i = '0;
    task_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_task_valid"}, 32'(task_valid_o), 0);
    chk({tag, "_task_op"}, 32'(task_op_o), 0);
    chk({tag, "_task_arg"}, 32'(task_arg_o), 0);
    chk({tag, "_soft_rst"}, 32'(soft_rst_o), 0);
    chk({tag, "_data"}, 32'(data_o), 0);
    chk({tag, "_data_valid"}, 32'(data_valid_o), 0);
    chk({tag, "_full"}, 32'(buffer_full_o), 0);
    chk({tag, "_irq"}, 32'(interrupt_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  function automatic logic [23:0] rand_cmd();
    int r;
    logic [3:0] op, sub;
    r = $urandom_range(0, 99);
    sub = 4'($urandom);
    if (r < 8)       op = 4'd0;
    else if (r < 12) begin op = 4'd1; sub = 4'($urandom_range(0, 5)); end
    else if (r < 30) op = 4'd2;
    else if (r < 50) op = 4'd3;
    else if (r < 94) op = 4'd4;
    else             op = 4'($urandom_range(5, 15));
    if (op == 4'd0) return 24'h0;
    return {op, sub, 16'($urandom)};
  endfunction

  // Monitor: one predicted output set per modelled edge.
  always @(posedge clk_i) begin
    exp_t e;
    logic [15:0] d;
    #1;
    if (rst_ni && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("soft_rst", 32'(soft_rst_o), 32'(e.srst));
      chk("data_valid", 32'(data_valid_o), 32'(e.dv));
      chk("buffer_full", 32'(buffer_full_o), 32'(e.full));
      chk("interrupt", 32'(interrupt_o), 32'(e.irq));
      chk("err", 32'(err_o), 32'(e.err));
      chk("task_valid", 32'(task_valid_o), 32'(e.tv));
      if (e.tv) begin
        chk("task_op", 32'(task_op_o), 32'(e.top));
        chk("task_arg", 32'(task_arg_o), 32'(e.targ));
      end
      if (e.dv && rd_q.size() > 0) begin
        d = rd_q.pop_front();
        chk("read_data", 32'(data_o), 32'(d));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    check_all_zero("por");

    // Command on the very first edge after release is executed.
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(24'h200ABC, 1'b0);
    step(24'h300000, 1'b0);
    step(24'h000000, 1'b0);

    // Fill to full, one dropped push, then drain in order.
    step(24'h400000, 1'b0);
    step(24'h400008, 1'b0);
    step(24'h400010, 1'b0);
    step(24'h400018, 1'b0);
    step(24'h400020, 1'b0);
    step(24'h000000, 1'b0);
    for (int i = 0; i < 6; i++) step(24'h000000, 1'b1);

    // Push and pop together while full.
    step(24'h410001, 1'b0);
    step(24'h420002, 1'b0);
    step(24'h430003, 1'b0);
    step(24'h440004, 1'b0);
    step(24'h400040, 1'b1);
    for (int i = 0; i < 6; i++) step(24'h000000, 1'b1);

    // RESET-ALL with two entries queued and a pop requested.
    step(24'h205555, 1'b0);
    step(24'h450001, 1'b0);
    step(24'h460002, 1'b0);
    step(24'h100000, 1'b1);
    step(24'h350000, 1'b1);
    for (int s = 1; s < 6; s++) step({4'd1, 4'(s), 16'h0}, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(rand_cmd(), ($urandom_range(0, 99) < 35));

    // Asynchronous reset with three entries queued.
    step(24'h100000, 1'b0);
    step(24'h200777, 1'b0);
    step(24'h400100, 1'b0);
    step(24'h400200, 1'b0);
    step(24'h400300, 1'b0);
    step(24'h300000, 1'b0);
    quiesce();
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    drive(24'h000000, 1'b0);
    step(24'h300000, 1'b1);
    step(24'h000000, 1'b1);
    quiesce();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("read_queue_drained", 32'(rd_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
